// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
// The PARITY state exists in the enum in every build. The transmitter only
// enters it when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // Byte width. It must match the width of the upstream FIFO.
  localparam int DATA_W = 8;

  // Default baud divisor: 50 MHz / 115200.
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // Width of the baud counter. A divisor of 2 still needs one bit.
  function automatic int baud_cnt_w(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

  localparam int BAUD_CNT_W = baud_cnt_w(CLKS_PER_BIT_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear.
// bit_end pulses for one cycle on the last clock of every bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Advance the bit-period counter, wrapping explicitly at the last count.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before this edge.
    if (sys_rst || clear) begin
      count <= '0;
    end else if (count == LAST_CNT) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_end = (count == LAST_CNT) && !clear && !sys_rst;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: sole reader of an 8-bit synchronous FIFO. It pops one byte per
// frame and shifts it out LSB first as UART 8N1 on a registered tx line.
// Optional feature: define UART_TX_PARITY_EN to send an even-parity bit
// between the last data bit and the stop bit (8E1).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  import uart_pkg::*;

  localparam int CNT_W = baud_cnt_w(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W <= 2) ? 1 : $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic              tx_d;
  logic              pop;
  logic              done;
  logic              bit_end;
  logic              baud_clear;

`ifdef UART_TX_PARITY_EN
  logic              parity;
`endif

  // The baud counter sits at zero until the frame's start bit begins.
  assign baud_clear = (state == IDLE) || (state == FETCH);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  // Next-state logic. tx_d is taken from the next state, so the registered tx
  // changes on the same edge as the state change.
  always_comb begin
    // NOTE: every output of this block gets a default first. No path leaves
    // a signal unassigned, so no latch is inferred.
    state_d = state;
    shift_d = shift;
    idx_d   = idx;
    pop     = 1'b0;
    done    = 1'b0;
    tx_d    = 1'b1;

    case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          pop     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // The registered FIFO data is valid in the cycle after the pop.
        shift_d = fifo_rd_data;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx + IDX_W'(1);
            shift_d = shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and line registers. A synchronous reset abandons any
  // frame in flight and discards the byte that was popped for it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      shift <= shift_d;
      idx   <= idx_d;
      tx    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Capture even parity of the whole byte before shifting destroys it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      parity <= 1'b0;
    end else if (state == FETCH) begin
      parity <= ^fifo_rd_data;
    end
  end
`endif

  // The pop and done strobes are masked during reset. This means the FIFO
  // loses no byte and no tx_done pulse is seen while reset is held.
  assign fifo_rd_en = pop && !sys_rst;
  assign tx_done    = done && !sys_rst;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
// A 1-cycle-latency FIFO model feeds the DUT. Every pushed byte is queued as
// an expected frame. A line monitor decodes each frame and compares it with
// the queue.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME   = NBITS * CPB;
  localparam int SPACING = FRAME + 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .tx_enable    (tx_enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // FIFO model: a push request is taken at a rising edge, and a pop returns
  // registered data one cycle later.
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  always @(posedge sys_clk) begin
    if (push_valid) fifo_q.push_back(push_data);
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic push_byte(input logic [7:0] b);
    push_data  = b;
    push_valid = 1'b1;
    exp_q.push_back(b);
    @(negedge sys_clk);
    push_valid = 1'b0;
  endtask

  // Global strobes: the cycle count and rd_en / tx_done bookkeeping.
  int cycle = 0;
  int rd_count = 0;
  int rd_bad = 0;
  int done_count = 0;

  always @(negedge sys_clk) begin
    cycle++;
    if (fifo_rd_en) begin
      rd_count++;
      if (fifo_empty || busy) rd_bad++;
    end
    if (tx_done) done_count++;
  end

  // Line monitor: decodes frames from the start-bit edge, checks the bit
  // widths, busy and the tx_done position, then scores against exp_q.
  int frames_done = 0;
  int abort_count = 0;
  int starts[$];

  initial begin : monitor
    logic       bitv[NBITS];
    logic [7:0] data;
    logic [7:0] want;
    bit         stable, busy_ok, done_ok, aborted;
    int         t0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && tx === 1'b0) begin
        t0 = cycle; stable = 1; busy_ok = 1; done_ok = 1; aborted = 0;
        for (int s = 0; s < FRAME; s++) begin
          if (s > 0) @(negedge sys_clk);
          if (sys_rst) begin aborted = 1; break; end
          if (s % CPB == 0) bitv[s / CPB] = tx;
          else if (tx !== bitv[s / CPB]) stable = 0;
          if (busy !== 1'b1) busy_ok = 0;
          if (tx_done !== (s == FRAME - 1)) done_ok = 0;
        end
        if (aborted) begin
          abort_count++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          for (int i = 0; i < 8; i++) data[i] = bitv[1 + i];
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check("frame_data", int'(data), int'(want));
          check("start_bit", int'(bitv[0]), 0);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", int'(bitv[9]), int'(^want));
`endif
          check("stop_bit", int'(bitv[NBITS-1]), 1);
          check("bit_width_stable", int'(stable), 1);
          check("busy_in_frame", int'(busy_ok), 1);
          check("tx_done_last_cycle", int'(done_ok), 1);
          starts.push_back(t0);
          frames_done++;
        end
      end
    end
  end

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check({"timeout_", tag}, int'(frames_done >= target), 1);
  endtask

  initial begin : stim
    int rd0, d0, n0, f0;
    bit tx_hi, busy_lo;

    // Reset: hold 3 cycles with the FIFO non-empty and tx_enable high.
    sys_rst   = 1'b1;
    tx_enable = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("rst_tx", int'(tx), 1);
      check("rst_rd_en", int'(fifo_rd_en), 0);
      check("rst_busy", int'(busy), 0);
    end
    sys_rst = 1'b0;
    #1;
    check("first_pop_after_rst", int'(fifo_rd_en), 1);

    // Single byte 0xA5.
    wait_frames("a5", 1, 200);
    @(negedge sys_clk);
    check("a5_rd_pulses", rd_count, 1);
    check("a5_done_pulses", done_count, 1);

    // Back-to-back 0x00, 0xFF.
    rd0 = rd_count; n0 = starts.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames("b2b", 3, 400);
    if (starts.size() >= n0 + 2)
      check("b2b_spacing", starts[n0+1] - starts[n0], SPACING);
    check("b2b_rd_pulses", rd_count - rd0, 2);

    // Empty FIFO, tx_enable held high for 100 cycles.
    rd0 = rd_count; tx_hi = 1; busy_lo = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1) tx_hi = 0;
      if (busy !== 1'b0) busy_lo = 0;
    end
    check("empty_no_pop", rd_count - rd0, 0);
    check("empty_tx_high", int'(tx_hi), 1);
    check("empty_not_busy", int'(busy_lo), 1);

    // tx_enable dropped during DATA of 0x3C, with 2 more bytes queued.
    rd0 = rd_count; d0 = done_count; f0 = frames_done;
    push_byte(8'h3C);
    push_byte(8'h5A);
    push_byte(8'hC3);
    repeat (20) @(negedge sys_clk);
    tx_enable = 1'b0;
    wait_frames("3c", f0 + 1, 200);
    repeat (60) @(negedge sys_clk);
    check("en_low_single_pop", rd_count - rd0, 1);
    check("en_low_done", done_count - d0, 1);
    check("en_low_fifo_left", fifo_q.size(), 2);
    check("en_low_idle_tx", int'(tx), 1);
    tx_enable = 1'b1;
    wait_frames("resume", f0 + 3, 400);
    check("resume_pops", rd_count - rd0, 3);

    // 0x07: odd popcount, so the parity bit (when present) is 1.
    f0 = frames_done;
    push_byte(8'h07);
    wait_frames("x07", f0 + 1, 200);

    // Reset asserted during DATA.
    push_byte(8'h81);
    repeat (18) @(negedge sys_clk);
    d0 = done_count;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(tx_done), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (60) @(negedge sys_clk);
    check("midrst_no_done", done_count - d0, 0);
    check("midrst_abort_seen", abort_count, 1);
    check("midrst_idle_tx", int'(tx), 1);

    // Final scoreboard state.
    check("rd_en_legal", rd_bad, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit in case the stimulus itself stalls.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
